cam_cfg_sequencer: RTL and testbench

Parametrised OV7670 configuration sequencer: walks a registered register-table ROM (entries {reg[7:0], value[7:0]}), selects one of several mode tables, and issues each register write to the SCCB master over a valid/ready request plus done/nack completion interface. It honours the delay and end-of-table tokens, retries NACKed writes, and reports busy/done/error to the top-level camera controller. It sits between the configuration ROM and the SCCB master.

---
 rtl/cam_cfg_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_cam_cfg_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cfg_sequencer.sv
// ============================================================================
// Module      : cam_cfg_sequencer
// Description : Walks a mode-selected register table and issues each entry as
//               an SCCB register write, handling delay/end tokens and retries.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cam_cfg_sequencer #(
    parameter int          MODE_W       = 2,
    parameter int          IDX_W        = 8,
    parameter int          DELAY_CYCLES = 240000,
    parameter logic [15:0] DELAY_TOKEN  = 16'hFFF0,
    parameter logic [15:0] END_TOKEN    = 16'hFFFF,
    parameter int          MAX_RETRY    = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_start,
    input  logic [MODE_W-1:0]       i_mode,
    output logic [MODE_W+IDX_W-1:0] o_rom_addr,
    input  logic [15:0]             i_rom_data,
    output logic                    o_wr_valid,
    input  logic                    i_wr_ready,
    output logic [7:0]              o_wr_reg,
    output logic [7:0]              o_wr_data,
    input  logic                    i_wr_done,
    input  logic                    i_wr_nack,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [IDX_W:0]          o_wr_count
);

    localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DLY_W-1:0] C_DLY_LAST  = DLY_W'(DELAY_CYCLES - 1);
    localparam logic [RTY_W-1:0] C_RETRY_MAX = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_DELAY     = 3'd5,
        S_FINISH    = 3'd6,
        S_ABORT     = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [MODE_W-1:0]  mode_q,  mode_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [DLY_W-1:0]   dly_q,   dly_d;
    logic [7:0]         reg_q,   reg_d;
    logic [7:0]         data_q,  data_d;
    logic [IDX_W:0]     cnt_q,   cnt_d;
    logic               err_q,   err_d;
    logic               w_advance;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            dly_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            dly_q   <= dly_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        dly_d     = dly_q;
        reg_d     = reg_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        w_advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mode_d  = i_mode;
                    idx_d   = '0;
                    retry_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (i_rom_data == END_TOKEN) begin
                    state_d = S_FINISH;
                end else if (i_rom_data == DELAY_TOKEN) begin
                    dly_d   = '0;
                    state_d = S_DELAY;
                end else begin
                    reg_d   = i_rom_data[15:8];
                    data_d  = i_rom_data[7:0];
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (i_wr_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_wr_done) begin
                    if (!i_wr_nack) begin
                        cnt_d     = cnt_q + 1'b1;
                        retry_d   = '0;
                        w_advance = 1'b1;
                    end else if (retry_q < C_RETRY_MAX) begin
                        // Same entry is reissued; reg/data registers are untouched.
                        retry_d = retry_q + 1'b1;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == C_DLY_LAST) begin
                    w_advance = 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ABORT: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The last table slot ends the run even without an end token.
        if (w_advance) begin
            if (idx_q == {IDX_W{1'b1}}) begin
                state_d = S_FINISH;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    assign o_rom_addr = {mode_q, idx_q};
    assign o_wr_valid = (state_q == S_SEND);
    assign o_wr_reg   = reg_q;
    assign o_wr_data  = data_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_FINISH);
    assign o_err      = err_q;
    assign o_wr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_cfg_sequencer.sv
// ============================================================================
// Module      : tb_cam_cfg_sequencer
// Description : Scoreboard bench for cam_cfg_sequencer with ROM and SCCB models.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cam_cfg_sequencer;

    localparam int LAT_A = 5;
    localparam int LAT_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, start_b;
    logic [1:0]  mode, mode_b;

    logic [9:0]  addr_a;
    logic [15:0] rdata_a;
    logic        valid_a, ready_a, m_done_a, inj_done, nack_a;
    logic [7:0]  reg_a, data_a;
    logic        busy_a, done_a, err_a;
    logic [8:0]  cnt_a;
    wire         done_in_a = m_done_a | inj_done;

    logic [3:0]  addr_b;
    logic [15:0] rdata_b;
    logic        valid_b, ready_b, m_done_b, nack_b;
    logic [7:0]  reg_b, data_b;
    logic        busy_b, done_b, err_b;
    logic [2:0]  cnt_b;

    logic [15:0] rom_a [0:1023];
    logic [15:0] rom_b [0:15];
    always @(posedge clk) rdata_a <= rom_a[addr_a];
    always @(posedge clk) rdata_b <= rom_b[addr_b];

    cam_cfg_sequencer #(
        .MODE_W(2), .IDX_W(8), .DELAY_CYCLES(8), .MAX_RETRY(3)
    ) u_dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_mode(mode),
        .o_rom_addr(addr_a), .i_rom_data(rdata_a),
        .o_wr_valid(valid_a), .i_wr_ready(ready_a),
        .o_wr_reg(reg_a), .o_wr_data(data_a),
        .i_wr_done(done_in_a), .i_wr_nack(nack_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_wr_count(cnt_a)
    );

    cam_cfg_sequencer #(
        .MODE_W(2), .IDX_W(2), .DELAY_CYCLES(8), .MAX_RETRY(3)
    ) u_dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_start(start_b), .i_mode(mode_b),
        .o_rom_addr(addr_b), .i_rom_data(rdata_b),
        .o_wr_valid(valid_b), .i_wr_ready(ready_b),
        .o_wr_reg(reg_b), .o_wr_data(data_b),
        .i_wr_done(m_done_b), .i_wr_nack(nack_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_wr_count(cnt_b)
    );

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    bit          nack_plan[$];
    int          hs_cyc[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          done_cnt_a = 0;
    int          bad_a = 0;
    int          bad_b = 0;
    int          wrap_b = 0;
    logic [1:0]  mode_exp_a = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // SCCB master model A: scoreboard pop on every handshake, done after LAT_A cycles.
    initial begin
        int pend;
        pend = 0;
        m_done_a = 1'b0;
        nack_a   = 1'b0;
        forever begin
            @(negedge clk);
            m_done_a = 1'b0;
            nack_a   = 1'b0;
            if (rstn !== 1'b1) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    m_done_a = 1'b1;
                    nack_a   = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
                end
            end else if (valid_a && ready_a) begin
                hs_cyc.push_back(cyc);
                if (exp_a.size() == 0) begin
                    total_cnt++;
                    $display("FAIL wr_a_extra: got %h required no write", {reg_a, data_a});
                end else begin
                    check("wr_a", 32'({reg_a, data_a}), 32'(exp_a.pop_front()));
                end
                pend = LAT_A;
            end
        end
    end

    // SCCB master model B: always ready, never NACKs.
    initial begin
        int pend;
        pend = 0;
        m_done_b = 1'b0;
        nack_b   = 1'b0;
        forever begin
            @(negedge clk);
            m_done_b = 1'b0;
            if (rstn !== 1'b1) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) m_done_b = 1'b1;
            end else if (valid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    total_cnt++;
                    $display("FAIL wr_b_extra: got %h required no write", {reg_b, data_b});
                end else begin
                    check("wr_b", 32'({reg_b, data_b}), 32'(exp_b.pop_front()));
                end
                pend = LAT_B;
            end
        end
    end

    // Address / done monitors.
    initial begin
        logic [3:0] prev_b;
        prev_b = 4'd0;
        forever begin
            @(negedge clk);
            if (done_a === 1'b1) done_cnt_a++;
            if (busy_a === 1'b1 && addr_a[9:8] !== mode_exp_a) bad_a++;
            if (busy_b === 1'b1) begin
                if (addr_b[3:2] !== 2'd1) bad_b++;
                if (addr_b < prev_b) wrap_b++;
                prev_b = addr_b;
            end else begin
                prev_b = 4'd0;
            end
        end
    end

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end_a(output bit got_done, output bit got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_a === 1'b1) begin got_done = 1'b1; break; end
            if (err_a === 1'b1 && busy_a === 1'b0) begin got_err = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic run_a(input string t, input logic [1:0] m, input bit expect_err,
                         input logic [8:0] exp_cnt, input logic [9:0] end_addr);
        bit gd, ge;
        int d0;
        d0 = done_cnt_a;
        mode_exp_a = m;
        pulse_start(m);
        check({t, "_busy_rise"}, 32'(busy_a), 32'd1);
        check({t, "_addr0"}, 32'(addr_a), 32'({m, 8'h00}));
        check({t, "_err_clr"}, 32'(err_a), 32'd0);
        repeat (2) @(negedge clk);
        pulse_start(~m);
        wait_end_a(gd, ge);
        if (expect_err) check({t, "_err"}, 32'(ge), 32'd1);
        else            check({t, "_done"}, 32'(gd), 32'd1);
        check({t, "_cnt"}, 32'(cnt_a), 32'(exp_cnt));
        check({t, "_end_addr"}, 32'(addr_a), 32'(end_addr));
        @(negedge clk);
        check({t, "_busy_fall"}, 32'(busy_a), 32'd0);
        check({t, "_done_pulses"}, 32'(done_cnt_a - d0), expect_err ? 32'd0 : 32'd1);
        check({t, "_sb_empty"}, 32'(exp_a.size()), 32'd0);
        check({t, "_mode_addr"}, 32'(bad_a), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom_a[i] = 16'hFFFF;
        for (int i = 0; i < 16; i++)   rom_b[i] = 16'hFFFF;
        rom_a[10'h000] = 16'h1280; rom_a[10'h001] = 16'hFFF0; rom_a[10'h002] = 16'h1204;
        rom_a[10'h100] = 16'h1100; rom_a[10'h101] = 16'h1234;
        rom_a[10'h200] = 16'h2A01; rom_a[10'h201] = 16'h2B02;
        rom_a[10'h300] = 16'h1301; rom_a[10'h301] = 16'h1400; rom_a[10'h302] = 16'h1505;
        rom_b[4] = 16'h2001; rom_b[5] = 16'h2102; rom_b[6] = 16'h2203; rom_b[7] = 16'h2304;

        rstn = 1'b0; start = 1'b0; mode = 2'd0; start_b = 1'b0; mode_b = 2'd0;
        ready_a = 1'b1; ready_b = 1'b1; inj_done = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_regdata", 32'({reg_a, data_a}), 32'd0);
        check("rst_done_err", 32'({done_a, err_a}), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);

        // Mode 0: write, delay token, write, end token.
        exp_a = {16'h1280, 16'h1204};
        hs_cyc.delete();
        run_a("m0", 2'd0, 1'b0, 9'd2, 10'h003);
        check("m0_gap", (hs_cyc.size() == 2) ? 32'(hs_cyc[1] - hs_cyc[0]) : 32'hFFFF_FFFF, 32'd18);

        exp_a = {16'h2A01, 16'h2B02};
        run_a("m2", 2'd2, 1'b0, 9'd2, 10'h202);

        // Two NACKs on the first entry, then success.
        exp_a = {16'h1100, 16'h1100, 16'h1100, 16'h1234};
        nack_plan = {1'b1, 1'b1};
        run_a("retry", 2'd1, 1'b0, 9'd2, 10'h102);

        // Second entry NACKs on all four attempts.
        exp_a = {16'h1301, 16'h1400, 16'h1400, 16'h1400, 16'h1400};
        nack_plan = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        run_a("abort", 2'd3, 1'b1, 9'd1, 10'h301);
        check("abort_plan_used", 32'(nack_plan.size()), 32'd0);

        // Reset while the second write of mode 2 is stalled in SEND.
        exp_a = {16'h2A01};
        hs_cyc.delete();
        mode_exp_a = 2'd2;
        pulse_start(2'd2);
        check("rst_run_err_clr", 32'(err_a), 32'd0);
        for (int i = 0; i < 200 && hs_cyc.size() == 0; i++) @(negedge clk);
        @(negedge clk);
        ready_a = 1'b0;
        for (int i = 0; i < 200 && valid_a !== 1'b1; i++) @(negedge clk);
        check("stall_valid", 32'(valid_a), 32'd1);
        check("stall_regdata", 32'({reg_a, data_a}), 32'h2B02);
        check("stall_cnt", 32'(cnt_a), 32'd1);
        check("stall_addr", 32'(addr_a), 32'h201);
        rstn = 1'b0; start = 1'b1; mode = 2'd1;
        @(negedge clk);
        rstn = 1'b1; start = 1'b0;
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_addr", 32'(addr_a), 32'd0);
        check("mid_rst_regdata", 32'({reg_a, data_a}), 32'd0);
        check("mid_rst_cnt", 32'(cnt_a), 32'd0);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        ready_a = 1'b1;
        repeat (2) @(negedge clk);
        check("late_done_busy", 32'(busy_a), 32'd0);
        check("late_done_cnt_err", 32'({cnt_a, err_a, done_a}), 32'd0);
        check("mid_rst_sb", 32'(exp_a.size()), 32'd0);

        exp_a = {16'h1280, 16'h1204};
        run_a("restart", 2'd0, 1'b0, 9'd2, 10'h003);

        // IDX_W=2 table with no end token: implicit finish after the last slot.
        exp_b = {16'h2001, 16'h2102, 16'h2203, 16'h2304};
        @(negedge clk);
        start_b = 1'b1; mode_b = 2'd1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_addr0", 32'(addr_b), 32'h4);
        for (int i = 0; i < 200 && done_b !== 1'b1; i++) @(negedge clk);
        check("b_done", 32'(done_b), 32'd1);
        check("b_cnt", 32'(cnt_b), 32'd4);
        check("b_end_addr", 32'(addr_b), 32'h7);
        check("b_err", 32'(err_b), 32'd0);
        @(negedge clk);
        check("b_busy_fall", 32'(busy_b), 32'd0);
        check("b_sb_empty", 32'(exp_b.size()), 32'd0);
        check("b_addr_range", 32'(bad_b), 32'd0);
        check("b_no_wrap", 32'(wrap_b), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
